// File: rtl/dmem_bus_bridge.sv
// Data-memory bus bridge: turns the mem stage's combinational RAM request into a
// registered req/ack bus cycle. Optional ack timeout enabled by DMEM_TIMEOUT_EN.
module dmem_bus_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [2:0]        mem_sel_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              stall_req_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic        access_ok;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
    assign bus_err_o  = 1'b0;
`endif

    // Size decode, alignment check and lane steering of the incoming request.
    always_comb begin
        access_ok  = 1'b0;
        be_next    = 4'b0000;
        wdata_next = 32'h0;
        case (mem_sel_i)
            3'b000: begin
                access_ok  = 1'b1;
                be_next    = 4'b0001 << mem_addr_i[1:0];
                wdata_next = {4{mem_wdata_i[7:0]}};
            end
            3'b001: begin
                access_ok  = ~mem_addr_i[0];
                be_next    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{mem_wdata_i[15:0]}};
            end
            3'b010: begin
                access_ok  = (mem_addr_i[1:0] == 2'b00);
                be_next    = 4'b1111;
                wdata_next = mem_wdata_i;
            end
            default: ;
        endcase
        if (!mem_we_i) begin
            wdata_next = 32'h0;
        end
    end

    // Stall must rise in the same cycle as the request so the pipeline never advances past it.
    assign stall_req_o = rst && (((state == IDLE) && mem_ce_i) || (state == BUSY));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= 4'b0000;
            bus_wdata_o <= 32'h0;
            mem_rdata_o <= 32'h0;
            misalign_o  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            bus_err_o   <= 1'b0;
            wait_cnt    <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    misalign_o <= 1'b0;
                    if (mem_ce_i) begin
                        if (access_ok) begin
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= mem_we_i;
                            bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                            bus_be_o    <= be_next;
                            bus_wdata_o <= wdata_next;
`ifdef DMEM_TIMEOUT_EN
                            wait_cnt    <= 8'h00;
`endif
                            state       <= BUSY;
                        end else begin
                            mem_rdata_o <= 32'h0;
                            misalign_o  <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack_i) begin
                        if (!bus_we_o) begin
                            mem_rdata_o <= bus_rdata_i;
                        end
                        bus_req_o <= 1'b0;
                        state     <= DONE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    // An ack on the final allowed cycle takes priority over the timeout.
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        bus_req_o   <= 1'b0;
                        mem_rdata_o <= 32'h0;
                        bus_err_o   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h01;
                    end
`endif
                end
                DONE: begin
                    misalign_o <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
                    bus_err_o  <= 1'b0;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the mem stage. It consumes that stage's combinational RAM request (ce/we/addr/sel/data) and turns it into a registered req/ack transaction on the data bus.
- Steers store data and byte enables to the correct lanes, returns the raw aligned read word to the mem stage, and holds the pipeline with a stall request until the access completes.
- Flags misaligned or illegal accesses without issuing a bus cycle.

Parameters:
- ADDR_W, 32, data-address width (bus_addr_o is word-aligned, bits [1:0] forced 0)
- TIMEOUT_CYCLES, 255, max cycles in BUSY waiting for bus_ack_i (used only with DMEM_TIMEOUT_EN); must be 1..255

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- mem_ce_i  in  1  access request from mem stage
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  ADDR_W  byte address
- mem_sel_i  in  3  access size: 000 byte, 001 half, 010 word; all other codes illegal
- mem_wdata_i  in  32  store data, right-justified (byte in [7:0]; half in [15:0] or duplicated)
- mem_rdata_o  out  32  captured read word, lane-aligned; mem stage extracts the byte/half
- stall_req_o  out  1  pipeline hold request
- misalign_o  out  1  one-cycle pulse in DONE when the access was misaligned or illegal
- bus_err_o  out  1  one-cycle pulse in DONE when the access timed out
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_addr_o  out  ADDR_W  word address
- bus_be_o  out  4  byte-lane enables
- bus_wdata_o  out  32  lane-steered write data
- bus_ack_i  in  1  transaction complete; read data valid this cycle
- bus_rdata_i  in  32  read data

Behaviour:
- Reset (rst = 0, async): state IDLE. All registered outputs are 0: bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, mem_rdata_o, misalign_o, bus_err_o. stall_req_o is forced 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, mem_ce_i = 0: stay in IDLE; stall_req_o = 0.
- IDLE, mem_ce_i = 1: stall_req_o = 1 combinationally. Then one of:
  - Access legal and aligned: register addr (word-aligned), we, be, steered wdata; set bus_req_o = 1; go to BUSY.
  - Misaligned or illegal: no bus cycle; mem_rdata_o <= 0; misalign_o <= 1; go to DONE.
- Alignment rules:
  - Half requires addr[0] = 0.
  - Word requires addr[1:0] = 00.
  - mem_sel_i not in {000, 001, 010} is illegal.
- Lane steering, byte: be = 0001 << addr[1:0]; wdata = {4{d[7:0]}}.
- Lane steering, half: be = addr[1] ? 1100 : 0011; wdata = {2{d[15:0]}}.
- Lane steering, word: be = 1111; wdata = d.
- Loads drive the same be; wdata is 0.
- BUSY:
  - bus_req_o, bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o are held stable.
  - stall_req_o = 1.
  - On bus_ack_i: mem_rdata_o <= bus_rdata_i for loads (unchanged for stores); bus_req_o <= 0; go to DONE.
- DONE:
  - stall_req_o = 0, so the pipeline advances at the end of this cycle.
  - misalign_o and bus_err_o may be high for this cycle only.
  - Next state is IDLE unconditionally; both flags are cleared on exit.
- Latency: request seen in cycle T0; bus_req_o high in T1; ack in T1 gives DONE in T2. Minimum is 3 cycles per access; back-to-back accesses see one IDLE cycle between them.
- bus_ack_i outside BUSY is ignored.
- mem_* inputs are sampled only in IDLE; changes during BUSY/DONE are ignored.
- Reset asserted mid-transaction: returns to IDLE immediately and drops bus_req_o; the bus slave must tolerate an abandoned request.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: bus_req_o <= 0; mem_rdata_o <= 0; bus_err_o <= 1; go to DONE.
  - An ack in the same cycle the count reaches TIMEOUT_CYCLES wins: normal completion, no error.
- Undefined: no counter; BUSY waits indefinitely; bus_err_o is tied to 0.

Test Plan:
- Load word, aligned: addr 0x100, sel 010, ack returned in T1 with rdata 0xDEADBEEF -> bus_be_o = 1111, bus_addr_o = 0x100; mem_rdata_o = 0xDEADBEEF and stall_req_o = 0 in T2; stall high in T0–T1.
- Store byte at 0x203, wdata 0x000000A5 -> bus_addr_o = 0x200, bus_be_o = 1000, bus_wdata_o = 0xA5A5A5A5, bus_we_o = 1; ack delayed 4 cycles -> stall held exactly until DONE.
- Store half at 0x302, d = 0x1234 -> be = 1100, wdata = 0x12341234. Load half at 0x301 -> no bus_req_o; misalign_o pulses in the cycle after ce; mem_rdata_o = 0.
- Illegal sel 011 with ce -> treated as misaligned; no bus activity.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> bus_req_o drops after 4 BUSY cycles; bus_err_o = 1 for one cycle; stall releases. Repeat with ack exactly on cycle 4 -> no error.
- rst pulled low during BUSY -> all outputs 0 immediately; after release a new word load completes normally.
